// File: rtl/ram_responder_pkg.sv
// Shared types and defaults for the RAM responder: FSM encoding, word width,
// default depth and access latency.
package ram_responder_pkg;

    localparam int WORD_W      = 32;
    localparam int DEPTH_DEF   = 1024;
    localparam int LATENCY_DEF = 4;
    localparam int CNT_W       = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/ram_responder_array.sv
// DEPTH x WORD_W storage: synchronous write port, asynchronous read port.
// Contents are not reset.
module ram_responder_array
    import ram_responder_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the change-detect cache protocol with fixed access latency.
// Optional build macro RAM_OOR_CHECK_EN adds err_o and out-of-range address handling.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [31:0]       addr_i,
    input  logic              wr_i,
    output logic              response_o,
    output logic [WORD_W-1:0] out_o
`ifdef RAM_OOR_CHECK_EN
    ,
    output logic              err_o
`endif
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_latency_range
        $error("ram_responder: LATENCY must be within 1..255");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              resp_q, resp_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              chg;
    logic              mem_we;
    logic [WORD_W-1:0] rdata;
    logic [ADDR_W-1:0] idx;
`ifdef RAM_OOR_CHECK_EN
    logic              err_q, err_d;
    logic              oor;

    assign oor   = (addr_q >= 32'(DEPTH));
    assign err_o = err_q;
`endif

    assign chg        = ({data_i, addr_i, wr_i} != {data_q, addr_q, wr_q});
    assign idx        = addr_q[ADDR_W-1:0];
    // A completion is masked the moment new inputs appear, before any edge.
    assign response_o = resp_q & ~chg;
    assign out_o      = out_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        out_d   = out_q;
        mem_we  = 1'b0;
`ifdef RAM_OOR_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (chg) begin
                    data_d  = data_i;
                    addr_d  = addr_i;
                    wr_d    = wr_i;
                    cnt_d   = CNT_LOAD;
                    resp_d  = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (chg) begin
                    // Abort: the pending op is dropped and the new one restarts the timer.
                    data_d = data_i;
                    addr_d = addr_i;
                    wr_d   = wr_i;
                    cnt_d  = CNT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef RAM_OOR_CHECK_EN
                    if (oor) begin
                        err_d = 1'b1;
                        if (!wr_q) out_d = '0;
                    end else begin
                        err_d  = 1'b0;
                        mem_we = wr_q;
                        if (!wr_q) out_d = rdata;
                    end
`else
                    mem_we = wr_q;
                    if (!wr_q) out_d = rdata;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= 1'b1;
            out_q   <= '0;
`ifdef RAM_OOR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            out_q   <= out_d;
`ifdef RAM_OOR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Reset on the completion edge must still suppress the write.
    ram_responder_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we & ~rst_i),
        .waddr_i (idx),
        .wdata_i (data_q),
        .raddr_i (idx),
        .rdata_o (rdata)
    );

endmodule
